// File: rtl/sfx_mixer_if.sv
// Signal bundle between the game logic / music generator and the speaker mixer.
// The master drives the music, triggers and volume; the slave returns the speaker and busy flag.
`timescale 1ns/1ps
interface sfx_mixer_if;
  logic       music_in;
  logic       music_en;
  logic [2:0] sfx_trig;
  logic [2:0] volume;
  logic       speaker;
  logic       sfx_busy;

  modport master (
    output music_in, music_en, sfx_trig, volume,
    input  speaker, sfx_busy
  );

  modport slave (
    input  music_in, music_en, sfx_trig, volume,
    output speaker, sfx_busy
  );
endinterface

// File: rtl/sfx_mixer.sv
// Final audio stage: background music, swept-tone / noise sound effects with music ducking,
// and 3-bit PWM volume gating onto a single registered speaker bit.
`timescale 1ns/1ps
module sfx_mixer #(
  parameter logic [23:0] SFX_LEN     = 24'd2_500_000,
  parameter int unsigned STEP_LOG2   = 16,
  parameter logic [15:0] SWEEP       = 16'd40,
  parameter logic [15:0] SHOOT_START = 16'd6000,
  parameter logic [15:0] JUMP_START  = 16'd12000,
  parameter logic [15:0] MIN_HALF    = 16'd500,
  parameter logic [15:0] HIT_HALF    = 16'd200
) (
  input  logic        clk,
  input  logic        reset,
  sfx_mixer_if.slave  bus
);

  typedef enum logic {IDLE, PLAY} state_e;
  // Encoding doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    FX_NONE  = 2'd0,
    FX_SHOOT = 2'd1,
    FX_JUMP  = 2'd2,
    FX_HIT   = 2'd3
  } fx_e;

  localparam logic [STEP_LOG2-1:0] STEP_ONE = STEP_LOG2'(1);

  state_e               state_q;
  fx_e                  cur_fx_q;
  logic [15:0]          half_q;
  logic [15:0]          half_cnt_q;
  logic                 tone_q;
  logic [23:0]          dur_cnt_q;
  logic [STEP_LOG2-1:0] step_cnt_q;
  logic [2:0]           pwm_cnt_q;
  logic [15:0]          lfsr_q;
  logic                 speaker_q;
  logic                 busy_q;

  fx_e         trig_fx;
  logic        start;
  logic        src;
  logic [15:0] start_half;
  logic [15:0] half_d;
  logic [15:0] lfsr_d;
  logic [16:0] sweep_sum;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    trig_fx = FX_NONE;
    if (bus.sfx_trig[2])      trig_fx = FX_HIT;
    else if (bus.sfx_trig[1]) trig_fx = FX_JUMP;
    else if (bus.sfx_trig[0]) trig_fx = FX_SHOOT;

    start = (trig_fx != FX_NONE) && ((state_q == IDLE) || (trig_fx >= cur_fx_q));

    start_half = SHOOT_START;
    case (trig_fx)
      FX_HIT:  start_half = HIT_HALF;
      FX_JUMP: start_half = JUMP_START;
      default: start_half = SHOOT_START;
    endcase

    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Shoot falls in pitch (saturating at the top), jump rises until the floor.
    sweep_sum = {1'b0, half_q} + {1'b0, SWEEP};
    half_d    = half_q;
    case (cur_fx_q)
      FX_SHOOT: half_d = sweep_sum[16] ? 16'hFFFF : sweep_sum[15:0];
      FX_JUMP:  half_d = ({1'b0, half_q} >= ({1'b0, MIN_HALF} + {1'b0, SWEEP}))
                         ? (half_q - SWEEP) : MIN_HALF;
      default:  half_d = half_q;
    endcase

    src = (state_q == PLAY) ? tone_q : (bus.music_in & bus.music_en);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_fx_q   <= FX_NONE;
      half_q     <= '0;
      half_cnt_q <= '0;
      tone_q     <= 1'b0;
      dur_cnt_q  <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      lfsr_q     <= 16'hACE1;
      speaker_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 3'd1;
      speaker_q <= src & (pwm_cnt_q < bus.volume);

      if (start) begin
        state_q    <= PLAY;
        cur_fx_q   <= trig_fx;
        half_q     <= start_half;
        half_cnt_q <= start_half - 16'd1;
        tone_q     <= 1'b1;
        dur_cnt_q  <= SFX_LEN - 24'd1;
        step_cnt_q <= '0;
        busy_q     <= 1'b1;
      end else if (state_q == PLAY) begin
        if (dur_cnt_q == '0) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tone_q  <= 1'b0;
        end else begin
          dur_cnt_q  <= dur_cnt_q - 24'd1;
          step_cnt_q <= step_cnt_q + STEP_ONE;
          // The swept half-period is only picked up at the next reload below.
          if (step_cnt_q == '1) half_q <= half_d;
          if (half_cnt_q == '0) begin
            half_cnt_q <= half_q - 16'd1;
            if (cur_fx_q == FX_HIT) begin
              lfsr_q <= lfsr_d;
              tone_q <= lfsr_d[0];
            end else begin
              tone_q <= ~tone_q;
            end
          end else begin
            half_cnt_q <= half_cnt_q - 16'd1;
          end
        end
      end
    end
  end

  assign bus.speaker  = speaker_q;
  assign bus.sfx_busy = busy_q;

endmodule

// File: tb/tb_sfx_mixer.sv
// Self-checking bench for sfx_mixer: a timestamp-based model of the mixer is compared with the
// DUT every cycle, and directed scenarios pin effect lengths, pitch sweeps and PWM duty.
`timescale 1ns/1ps
module tb_sfx_mixer;

  localparam int          SFX_LEN     = 1000;
  localparam int unsigned STEP_LOG2   = 4;
  localparam int          SWEEP       = 2;
  localparam int          SHOOT_START = 10;
  localparam int          JUMP_START  = 40;
  localparam int          MIN_HALF    = 30;
  localparam int          HIT_HALF    = 8;

  logic clk;
  logic reset;
  sfx_mixer_if bus();

  sfx_mixer #(
    .SFX_LEN     (24'(SFX_LEN)),
    .STEP_LOG2   (STEP_LOG2),
    .SWEEP       (16'(SWEEP)),
    .SHOOT_START (16'(SHOOT_START)),
    .JUMP_START  (16'(JUMP_START)),
    .MIN_HALF    (16'(MIN_HALF)),
    .HIT_HALF    (16'(HIT_HALF))
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Time is counted in clock edges since reset; an effect is described by its start edge,
  // and the half-period in force at any edge follows from how many sweep steps have elapsed.
  int unsigned m_cyc;
  int unsigned m_t0;
  int unsigned m_next;
  int          m_kind;
  logic        m_busy;
  logic        m_tone;
  logic        m_spk;
  logic [15:0] m_lfsr;
  int          toggle_log[$];

  function automatic int half_at(input int kind, input int unsigned elapsed);
    int k;
    int h;
    k = (elapsed == 0) ? 0 : int'((elapsed - 1) >> STEP_LOG2);
    case (kind)
      3: h = HIT_HALF;
      2: begin
        h = JUMP_START - SWEEP * k;
        if (h < MIN_HALF) h = MIN_HALF;
      end
      default: begin
        h = SHOOT_START + SWEEP * k;
        if (h > 65535) h = 65535;
      end
    endcase
    return h;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc  = 0;
      m_t0   = 0;
      m_next = 0;
      m_kind = 0;
      m_busy = 1'b0;
      m_tone = 1'b0;
      m_spk  = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      int   pr;
      logic src;
      src   = m_busy ? m_tone : (bus.music_in & bus.music_en);
      m_spk = src & ((m_cyc % 8) < bus.volume);
      pr = bus.sfx_trig[2] ? 3 : bus.sfx_trig[1] ? 2 : bus.sfx_trig[0] ? 1 : 0;
      if (pr != 0 && (!m_busy || pr >= m_kind)) begin
        m_busy = 1'b1;
        m_kind = pr;
        m_t0   = m_cyc;
        m_tone = 1'b1;
        m_next = m_cyc + half_at(pr, 0);
        toggle_log.delete();
      end else if (m_busy) begin
        if (m_cyc - m_t0 == SFX_LEN) begin
          m_busy = 1'b0;
          m_tone = 1'b0;
        end else if (m_cyc == m_next) begin
          if (m_kind == 3) begin
            m_lfsr = lfsr_step(m_lfsr);
            m_tone = m_lfsr[0];
          end else begin
            m_tone = ~m_tone;
          end
          toggle_log.push_back(int'(m_cyc - m_t0));
          m_next = m_cyc + half_at(m_kind, m_cyc - m_t0);
        end
      end
      m_cyc++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset === 1'b0) begin
      check("speaker", bus.speaker, m_spk);
      check("sfx_busy", bus.sfx_busy, m_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input logic [2:0] t);
    bus.sfx_trig = t;
    @(negedge clk);
    bus.sfx_trig = 3'b000;
  endtask

  task automatic count_ones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.speaker === 1'b1) n++;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.sfx_busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n;
  int exp_shoot[4] = '{10, 20, 32, 44};
  int exp_jump[5]  = '{40, 76, 108, 138, 168};

  initial begin
    bus.music_in = 1'b0;
    bus.music_en = 1'b0;
    bus.sfx_trig = 3'b000;
    bus.volume   = 3'd0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_speaker", bus.speaker, 1'b0);
    check("reset_busy", bus.sfx_busy, 1'b0);
    check("reset_lfsr", u_dut.lfsr_q, 16'hACE1);

    // Music pass-through and PWM duty
    reset = 1'b0;
    bus.music_in = 1'b1;
    bus.music_en = 1'b1;
    bus.volume   = 3'd7;
    count_ones(8, n);
    check("music_vol7_duty", n, 7);
    bus.volume = 3'd3;
    count_ones(8, n);
    check("music_vol3_duty", n, 3);
    bus.volume = 3'd0;
    count_ones(16, n);
    check("music_vol0_mute", n, 0);
    bus.volume   = 3'd7;
    bus.music_en = 1'b0;
    count_ones(16, n);
    check("music_disabled", n, 0);
    bus.music_en = 1'b1;

    // Shoot: exact length and falling pitch
    pulse(3'b001);
    check("shoot_busy_start", bus.sfx_busy, 1'b1);
    count_busy(n);
    check("shoot_len", n, SFX_LEN);
    for (int i = 0; i < 4; i++)
      check("shoot_toggle", (toggle_log.size() > i) ? toggle_log[i] : -1, exp_shoot[i]);
    repeat (5) @(negedge clk);

    // Jump: rising pitch saturating at the floor
    pulse(3'b010);
    count_busy(n);
    check("jump_len", n, SFX_LEN);
    for (int i = 0; i < 5; i++)
      check("jump_toggle", (toggle_log.size() > i) ? toggle_log[i] : -1, exp_jump[i]);
    repeat (5) @(negedge clk);

    // Priority: hit wins, lower priority ignored, equal priority restarts
    pulse(3'b111);
    repeat (199) @(negedge clk);
    pulse(3'b001);
    count_busy(n);
    check("hit_ignores_shoot", n, SFX_LEN - 200);
    repeat (5) @(negedge clk);
    pulse(3'b100);
    repeat (299) @(negedge clk);
    pulse(3'b100);
    count_busy(n);
    check("hit_restart_len", n, SFX_LEN);
    repeat (5) @(negedge clk);

    // Boundary: trigger sampled on the final PLAY edge
    pulse(3'b001);
    repeat (SFX_LEN - 1) @(negedge clk);
    check("boundary_pre_busy", bus.sfx_busy, 1'b1);
    pulse(3'b001);
    check("boundary_no_gap", bus.sfx_busy, 1'b1);
    count_busy(n);
    check("boundary_new_len", n, SFX_LEN);
    repeat (5) @(negedge clk);

    // Reset in the middle of a hit effect
    pulse(3'b100);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midplay_reset_speaker", bus.speaker, 1'b0);
    check("midplay_reset_busy", bus.sfx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check("midplay_reset_lfsr", u_dut.lfsr_q, 16'hACE1);
    pulse(3'b100);
    count_busy(n);
    check("hit_after_reset_len", n, SFX_LEN);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
